// File: rtl/pipe_ctl.sv
// Execute-stage sequencing controller: resolves memory, multi-cycle and
// redirect hazards into one stall/clear set for IF, ID, EX and EX/MA.
module pipe_ctl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             bj_en,
  input  logic             trap_en,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             ma_req,
  input  logic             ma_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             clear_id,
  output logic             clear_ex,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0]  BUBBLES = 2'(REDIRECT_BUBBLES);
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            st;
  logic [1:0]        fl_cnt;
  logic [15:0]       to_cnt;
  logic              err_q;
  logic [CNT_W-1:0]  st_cnt;

  logic memstall;
  logic mdstall;
  logic redir_req;
  logic redir_ok;
  logic rs1_hit;
  logic rs2_hit;
  logic loaduse;

  assign memstall  = ma_req & ~ma_ack;
  assign mdstall   = ((st == RUN) & md_start & ~md_done)
                   | ((st == MD_BUSY) & ~md_done);
  assign redir_req = bj_en | trap_en;
  assign redir_ok  = redir_req & ~memstall & ~mdstall;

  assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
  assign loaduse = id_valid & ex_valid & ex_load
                 & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  // Strobes are forced low while reset is held, even mid-stall.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    clear_id = 1'b0;
    clear_ex = 1'b0;
    if (!rst_n) begin
      stall_if = 1'b0;
    end else if (memstall | mdstall) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else if (redir_req) begin
      clear_id = 1'b1;
      clear_ex = 1'b1;
    end else if (st == FLUSH) begin
      clear_id = 1'b1;
    end else if (loaduse) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      clear_ex = 1'b1;
    end
  end

  // FSM and flush counter hold still during a memory stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= RUN;
      fl_cnt <= 2'd0;
    end else if (!memstall) begin
      if (redir_ok) begin
        if (REDIRECT_BUBBLES > 0) begin
          st     <= FLUSH;
          fl_cnt <= BUBBLES;
        end else begin
          st <= RUN;
        end
      end else begin
        unique case (st)
          RUN:     if (md_start & ~md_done) st <= MD_BUSY;
          MD_BUSY: if (md_done) st <= RUN;
          FLUSH: begin
            if (fl_cnt <= 2'd1) st <= RUN;
            else fl_cnt <= fl_cnt - 2'd1;
          end
          default: st <= RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= 16'd0;
      err_q  <= 1'b0;
    end else if (memstall) begin
      if (to_cnt == TO_LAST) begin
        to_cnt <= 16'd0;
        err_q  <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 16'd1;
        err_q  <= 1'b0;
      end
    end else begin
      to_cnt <= 16'd0;
      err_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_cnt <= '0;
    end else if (stall_if && (st_cnt != '1)) begin
      st_cnt <= st_cnt + CNT_ONE;
    end
  end

  assign mem_err      = err_q;
  assign state        = st;
  assign stall_cycles = st_cnt;

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl: per-cycle behavioural model compare plus
// hand-computed checkpoints along the scenario.
module tb_pipe_ctl;

  localparam int BUB = 1;
  localparam int TMO = 3;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic ex_valid = 0, ex_load = 0, bj_en = 0, trap_en = 0;
  logic md_start = 0, md_done = 0, ma_req = 0, ma_ack = 0;
  logic stall_if, stall_id, stall_ex, clear_id, clear_ex, mem_err;
  logic [1:0] state;
  logic [CW-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  pipe_ctl #(
    .REDIRECT_BUBBLES(BUB),
    .MEM_TIMEOUT(TMO),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_load(ex_load),
    .bj_en(bj_en), .trap_en(trap_en),
    .md_start(md_start), .md_done(md_done),
    .ma_req(ma_req), .ma_ack(ma_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .clear_id(clear_id), .clear_ex(clear_ex), .mem_err(mem_err),
    .state(state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: busy flag, remaining flush bubbles, length of the memory-stall
  // run ending last cycle, and the saturating stall tally.
  bit m_busy = 0;
  int m_flush = 0;
  int m_run = 0;
  int m_cnt = 0;

  always @(negedge clk) begin
    int e_sif, e_sid, e_sex, e_cid, e_cex, e_err, e_st;
    bit ms, mds, run, redir, lu;
    e_sif = 0; e_sid = 0; e_sex = 0; e_cid = 0; e_cex = 0;
    e_err = 0; e_st = 0;
    if (!rst_n) begin
      m_busy = 0; m_flush = 0; m_run = 0; m_cnt = 0;
      chk("m_rst", {stall_if, stall_id, stall_ex, clear_id,
                    clear_ex, mem_err, state, stall_cycles}, 0);
    end else begin
      run = !m_busy && m_flush == 0;
      ms  = ma_req && !ma_ack;
      mds = (run && md_start && !md_done) || (m_busy && !md_done);
      redir = (bj_en || trap_en) && !ms && !mds;
      lu = id_valid && ex_valid && ex_load && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) ||
            (id_use_rs2 && id_rs2 == ex_rd));
      if (ms || mds) begin
        e_sif = 1; e_sid = 1; e_sex = 1;
      end else if (bj_en || trap_en) begin
        e_cid = 1; e_cex = 1;
      end else if (m_flush > 0) begin
        e_cid = 1;
      end else if (lu) begin
        e_sif = 1; e_sid = 1; e_cex = 1;
      end
      e_err = (m_run > 0 && m_run % TMO == 0) ? 1 : 0;
      e_st = m_busy ? 1 : (m_flush > 0 ? 2 : 0);
      chk("m_stall_if", stall_if, e_sif);
      chk("m_stall_id", stall_id, e_sid);
      chk("m_stall_ex", stall_ex, e_sex);
      chk("m_clear_id", clear_id, e_cid);
      chk("m_clear_ex", clear_ex, e_cex);
      chk("m_mem_err", mem_err, e_err);
      chk("m_state", state, e_st);
      chk("m_stall_cycles", stall_cycles, m_cnt);
      if (ms) begin
        m_run++;
      end else begin
        m_run = 0;
        if (redir) begin
          m_busy = 0;
          m_flush = BUB;
        end else if (m_busy && md_done) begin
          m_busy = 0;
        end else if (run && mds) begin
          m_busy = 1;
        end else if (m_flush > 0) begin
          m_flush--;
        end
      end
      if (e_sif == 1 && m_cnt < SAT) m_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_cnt", stall_cycles, 0);
    tick();
    rst_n = 1;

    // load x5 then use as rs2
    id_valid = 1; id_rs2 = 5; id_use_rs2 = 1;
    ex_valid = 1; ex_load = 1; ex_rd = 5;
    @(negedge clk);
    chk("lu_stall_if", stall_if, 1);
    chk("lu_stall_ex", stall_ex, 0);
    chk("lu_clear_ex", clear_ex, 1);
    tick();
    ex_load = 0;
    @(negedge clk);
    chk("lu_release", {stall_if, stall_id, clear_ex}, 0);
    chk("lu_cnt", stall_cycles, 1);
    tick();
    ex_load = 1; ex_rd = 0; id_rs2 = 0;
    @(negedge clk);
    chk("x0_no_stall", stall_if, 0);
    tick();
    id_valid = 0; id_use_rs2 = 0; ex_valid = 0; ex_load = 0;

    // bj alone, then bj+trap as one redirect
    for (int k = 0; k < 2; k++) begin
      bj_en = 1; trap_en = (k == 1);
      @(negedge clk);
      chk("rd_clears", {clear_id, clear_ex}, 3);
      tick();
      bj_en = 0; trap_en = 0;
      @(negedge clk);
      chk("rd_flush_st", state, 2);
      chk("rd_flush_clr", {clear_id, clear_ex}, 2);
      tick();
      @(negedge clk);
      chk("rd_run", state, 0);
      chk("rd_idle", clear_id, 0);
      tick();
    end

    // multi-cycle op, done four cycles later
    md_start = 1;
    @(negedge clk);
    chk("md0_stall", {stall_if, stall_id, stall_ex}, 7);
    tick();
    md_start = 0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("md_busy_st", state, 1);
      chk("md_busy_stall", stall_ex, 1);
      tick();
    end
    md_done = 1;
    @(negedge clk);
    chk("md_done_nostall", stall_if, 0);
    tick();
    md_done = 0;
    @(negedge clk);
    chk("md_back_run", state, 0);
    tick();
    md_start = 1; md_done = 1;
    @(negedge clk);
    chk("md_same_cycle", stall_if, 0);
    tick();
    md_start = 0; md_done = 0;
    @(negedge clk);
    chk("md_same_st", state, 0);
    chk("md_cnt", stall_cycles, 5);
    tick();

    // memory timeout with a redirect pending underneath
    ma_req = 1;
    for (int i = 0; i < 7; i++) begin
      if (i >= 1) bj_en = 1;
      @(negedge clk);
      chk("mem_stall", {stall_if, stall_id, stall_ex}, 7);
      chk("mem_noclr", {clear_id, clear_ex}, 0);
      chk("mem_err_pulse", mem_err, (i == 3 || i == 6) ? 1 : 0);
      tick();
    end
    ma_ack = 1;
    @(negedge clk);
    chk("mem_ack_drop", stall_if, 0);
    chk("mem_ack_redir", clear_ex, 1);
    tick();
    ma_req = 0; ma_ack = 0; bj_en = 0;
    @(negedge clk);
    chk("mem_flush", state, 2);
    chk("mem_cnt", stall_cycles, 12);
    tick();

    // long op drives the tally into saturation
    md_start = 1;
    tick();
    md_start = 0;
    repeat (5) tick();
    md_done = 1;
    @(negedge clk);
    chk("sat_done", stall_if, 0);
    chk("sat_cnt", stall_cycles, SAT);
    tick();
    md_done = 0;

    // reset in the middle of MD_BUSY
    md_start = 1;
    tick();
    md_start = 0;
    @(negedge clk);
    chk("pre_rst_busy", state, 1);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_async_out", {stall_if, stall_id, stall_ex,
                          clear_id, clear_ex, mem_err}, 0);
    chk("rst_async_st", state, 0);
    chk("rst_async_cnt", stall_cycles, 0);
    tick();
    rst_n = 1;
    md_done = 1;
    @(negedge clk);
    chk("post_rst_done", stall_if, 0);
    chk("post_rst_st", state, 0);
    tick();
    md_done = 0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctl.md
Name: pipe_ctl

Overview:
Pipeline sequencing controller for the execute stage and its neighbours.
- Generates the stall and clear strobes for the IF, ID, EX and EX/MA registers.
- Stall sources: load-use hazards, outstanding memory accesses in MA, multi-cycle EX operations.
- Flush sources: branch/jump redirects and trap redirects leaving EX.
- Single point of priority resolution, so the execute stage sees one coherent stall/clear pair.

Parameters:
REDIRECT_BUBBLES, 1, extra cycles after a redirect during which clear_id stays high (0..3).
MEM_TIMEOUT, 255, cycles of unacknowledged ma_req before mem_err pulses (1..65535).
CNT_W, 32, width of the stall performance counter.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a valid instruction
id_rs1  input  5  ID source register 1
id_rs2  input  5  ID source register 2
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_valid  input  1  EX holds a valid instruction
ex_rd  input  5  EX destination register
ex_load  input  1  EX instruction is a load
bj_en  input  1  branch/jump redirect from EX
trap_en  input  1  trap redirect from EX
md_start  input  1  EX holds a multi-cycle op, first cycle
md_done  input  1  multi-cycle unit result valid this cycle
ma_req  input  1  MA stage has a bus access pending
ma_ack  input  1  bus completes the MA access this cycle
stall_if  output  1  hold PC/IF
stall_id  output  1  hold IF/ID register
stall_ex  output  1  hold ID/EX register and EX/MA inputs
clear_id  output  1  squash IF/ID register
clear_ex  output  1  squash ID/EX register (insert bubble)
mem_err  output  1  one-cycle timeout pulse
state  output  2  current FSM state, for debug
stall_cycles  output  CNT_W  saturating count of cycles with stall_if=1

Behaviour:
Reset:
- Asserting rst_n low sets state=RUN and all counters to 0.
- All outputs read 0 while in reset. This holds mid-operation and mid-stall; no pending event survives reset.

FSM states and encodings: RUN=0, MD_BUSY=1, FLUSH=2.
- RUN -> MD_BUSY: md_start & !md_done & !memstall.
- MD_BUSY -> RUN: md_done.
- RUN -> FLUSH: accepted redirect and REDIRECT_BUBBLES>0. Load flush counter with REDIRECT_BUBBLES.
- FLUSH: counter decrements each cycle. Return to RUN when it reaches 1.

Definitions:
- memstall = ma_req & !ma_ack (combinational).
- mdstall = (state==RUN & md_start & !md_done) | (state==MD_BUSY & !md_done).
- loaduse = id_valid & ex_valid & ex_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).

All stall/clear outputs are combinational from state and inputs, in the same cycle. Priority, highest first:
1. memstall: stall_if=stall_id=stall_ex=1; clears 0. FSM and flush counter frozen.
2. mdstall: stall_if=stall_id=stall_ex=1; clears 0.
3. Redirect (bj_en|trap_en, accepted only when neither stall above is active): clear_id=clear_ex=1, stalls 0. trap_en and bj_en together count as one redirect.
4. FLUSH state: clear_id=1, all others 0.
5. loaduse: stall_if=stall_id=1, clear_ex=1, stall_ex=0.
6. Otherwise: all 0.

Redirects while a stall is active are ignored. EX logic holds bj_en/trap_en stable under stall_ex, so they are re-presented after the stall.

Multi-cycle ops:
- md_start and md_done in the same cycle: no stall, remain in RUN.
- md_done in RUN without a preceding start is ignored.

Memory timeout:
- Timeout counter increments while memstall and clears when memstall drops.
- When it reaches MEM_TIMEOUT: mem_err=1 for exactly one cycle, counter clears, stall continues.

stall_cycles:
- Increments on every cycle with stall_if=1.
- Saturates at all-ones; no wrap.

Test Plan:
- Load x5 in EX with ex_rd=5; ID reads rs2=5 with id_use_rs2=1 -> one cycle of stall_if=stall_id=clear_ex=1, stall_ex=0. Next cycle with ex_load=0 -> all 0. stall_cycles=1.
- Same load-use but ex_rd=0 -> no stall.
- bj_en one cycle, REDIRECT_BUBBLES=1 -> cycle0 clear_id=clear_ex=1; cycle1 state=FLUSH, clear_id=1 only; cycle2 state=RUN, all 0.
- bj_en and trap_en both asserted -> handled as a single redirect: cycle0 clear_id=clear_ex=1, then the same FLUSH sequence.
- md_start, then md_done 4 cycles later -> stall_if=stall_id=stall_ex=1 for cycles 0..3, state=MD_BUSY cycles 1..3, 0 on cycle 4. md_start with md_done in the same cycle -> no stall.
- MEM_TIMEOUT=3, ma_req=1, ma_ack=0 for 7 cycles -> full stall throughout, mem_err pulses on cycles 3 and 6. bj_en asserted during this window is ignored. ma_ack=1 -> stall drops that cycle.
- rst_n pulsed low during MD_BUSY -> all outputs 0 immediately, state=RUN, stall_cycles=0. A later md_done with no new start produces no stall.
